// File: rtl/multi_cycle_ctrl_if.sv
// Control bundle between the multi-cycle controller (master) and datapath (slave).
interface multi_cycle_ctrl_if;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic        zero;
   logic [2:0]  alu_op;
   logic        alu_src_a;
   logic [1:0]  alu_src_b;
   logic        ext_zero;
   logic        pc_en;
   logic [1:0]  pc_source;
   logic        i_or_d;
   logic        mem_read;
   logic        mem_write;
   logic        ir_write;
   logic        reg_dst;
   logic        mem_to_reg;
   logic        reg_write;
   logic [3:0]  state;
   logic        halted;
   logic [31:0] instr_count;

   modport master (
      input  opcode, funct, zero,
      output alu_op, alu_src_a, alu_src_b, ext_zero, pc_en, pc_source,
      output i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
      output reg_write, state, halted, instr_count
   );

   modport slave (
      output opcode, funct, zero,
      input  alu_op, alu_src_a, alu_src_b, ext_zero, pc_en, pc_source,
      input  i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
      input  reg_write, state, halted, instr_count
   );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU control FSM: sequences IF/ID/EX/MEM/WB and drives datapath controls.
module multi_cycle_ctrl (
   input  logic               clk,
   input  logic               rst,
   multi_cycle_ctrl_if.master bus
);
   typedef enum logic [3:0] {
      S_IF    = 4'd0,
      S_ID    = 4'd1,
      S_MADDR = 4'd2,
      S_MRD   = 4'd3,
      S_MWB   = 4'd4,
      S_MWR   = 4'd5,
      S_EXR   = 4'd6,
      S_RWB   = 4'd7,
      S_BR    = 4'd8,
      S_JMP   = 4'd9,
      S_EXI   = 4'd10,
      S_IWB   = 4'd11,
      S_HALT  = 4'd12
   } state_e;

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_ORI  = 6'h0D;
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_HALT = 6'h3F;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b111;

   state_e      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;

   logic [2:0]  fn_op;
   logic        fn_ok;

   logic        pc_write, pc_write_cond, retire;
   logic        mr, mw, irw, rw;
   logic [2:0]  alu_op;
   logic        src_a, ext_zero, i_or_d, reg_dst, mem_to_reg;
   logic [1:0]  src_b, pc_source;

   always_comb begin
      fn_ok = 1'b1;
      fn_op = ALU_ADD;
      case (bus.funct)
         6'h20:   fn_op = ALU_ADD;
         6'h22:   fn_op = ALU_SUB;
         6'h24:   fn_op = ALU_AND;
         6'h25:   fn_op = ALU_OR;
         6'h2A:   fn_op = ALU_SLT;
         default: fn_ok = 1'b0;
      endcase
   end

   always_comb begin
      state_d = S_IF;
      case (state_q)
         S_IF: state_d = S_ID;
         S_ID: begin
            case (bus.opcode)
               OP_LW, OP_SW:    state_d = S_MADDR;
               OP_R:            state_d = S_EXR;
               OP_BEQ:          state_d = S_BR;
               OP_J:            state_d = S_JMP;
               OP_ADDI, OP_ORI: state_d = S_EXI;
               OP_HALT:         state_d = S_HALT;
               default:         state_d = S_IF;
            endcase
         end
         S_MADDR: state_d = (bus.opcode == OP_SW) ? S_MWR : S_MRD;
         S_MRD:   state_d = S_MWB;
         S_EXR:   state_d = S_RWB;
         S_EXI:   state_d = S_IWB;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_IF;
      endcase
   end

   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      retire        = 1'b0;
      mr            = 1'b0;
      mw            = 1'b0;
      irw           = 1'b0;
      rw            = 1'b0;
      alu_op        = ALU_ADD;
      src_a         = 1'b0;
      src_b         = 2'b00;
      ext_zero      = 1'b0;
      pc_source     = 2'b00;
      i_or_d        = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      case (state_q)
         S_IF: begin
            mr       = 1'b1;
            irw      = 1'b1;
            pc_write = 1'b1;
            src_b    = 2'b01;
         end
         S_ID: src_b = 2'b11;
         S_MADDR: begin
            src_a = 1'b1;
            src_b = 2'b10;
         end
         S_MRD: begin
            mr     = 1'b1;
            i_or_d = 1'b1;
         end
         S_MWB: begin
            rw         = 1'b1;
            mem_to_reg = 1'b1;
            retire     = 1'b1;
         end
         S_MWR: begin
            mw     = 1'b1;
            i_or_d = 1'b1;
            retire = 1'b1;
         end
         S_EXR: begin
            src_a  = 1'b1;
            alu_op = fn_op;
         end
         // Unknown funct retires as a NOP: RWB runs but never writes.
         S_RWB: begin
            rw      = fn_ok;
            reg_dst = 1'b1;
            retire  = 1'b1;
         end
         S_BR: begin
            src_a         = 1'b1;
            alu_op        = ALU_SUB;
            pc_write_cond = 1'b1;
            pc_source     = 2'b01;
            retire        = 1'b1;
         end
         S_JMP: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
            retire    = 1'b1;
         end
         S_EXI: begin
            src_a = 1'b1;
            src_b = 2'b10;
            if (bus.opcode == OP_ORI) begin
               alu_op   = ALU_OR;
               ext_zero = 1'b1;
            end
         end
         S_IWB: begin
            rw     = 1'b1;
            retire = 1'b1;
         end
         default: ;
      endcase
   end

   assign cnt_d = cnt_q + {31'd0, retire};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IF;
         cnt_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.pc_en       = ~rst & (pc_write | (pc_write_cond & bus.zero));
   assign bus.mem_read    = ~rst & mr;
   assign bus.mem_write   = ~rst & mw;
   assign bus.ir_write    = ~rst & irw;
   assign bus.reg_write   = ~rst & rw;
   assign bus.alu_op      = alu_op;
   assign bus.alu_src_a   = src_a;
   assign bus.alu_src_b   = src_b;
   assign bus.ext_zero    = ext_zero;
   assign bus.pc_source   = pc_source;
   assign bus.i_or_d      = i_or_d;
   assign bus.reg_dst     = reg_dst;
   assign bus.mem_to_reg  = mem_to_reg;
   assign bus.state       = state_q;
   assign bus.halted      = (state_q == S_HALT);
   assign bus.instr_count = cnt_q;
endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl: per-cycle expected controls queued, monitor compares.
module tb_multi_cycle_ctrl;
   typedef struct packed {
      logic [3:0] st;
      logic [2:0] op;
      logic       a;
      logic [1:0] b;
      logic       ext;
      logic       pce;
      logic [1:0] pcs;
      logic       iord;
      logic       mr;
      logic       mw;
      logic       irw;
      logic       rdst;
      logic       m2r;
      logic       rw;
      logic       halt;
   } vec_t;

   typedef struct {
      string       nm;
      vec_t        o;
      logic [31:0] cnt;
   } exp_t;

   logic clk;
   logic rst;
   multi_cycle_ctrl_if bus();

   multi_cycle_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   exp_t q[$];
   int   n_pass;
   int   n_total;

   logic [5:0] cur_op;
   logic [5:0] cur_fn;
   logic       cur_z;
   logic       cur_rst;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t v(
      input int st, input int op, input int a, input int b, input int ext,
      input int pce, input int pcs, input int iord, input int mr, input int mw,
      input int irw, input int rdst, input int m2r, input int rw, input int halt);
      vec_t r;
      r.st   = 4'(st);
      r.op   = 3'(op);
      r.a    = 1'(a);
      r.b    = 2'(b);
      r.ext  = 1'(ext);
      r.pce  = 1'(pce);
      r.pcs  = 2'(pcs);
      r.iord = 1'(iord);
      r.mr   = 1'(mr);
      r.mw   = 1'(mw);
      r.irw  = 1'(irw);
      r.rdst = 1'(rdst);
      r.m2r  = 1'(m2r);
      r.rw   = 1'(rw);
      r.halt = 1'(halt);
      return r;
   endfunction

   //                 st op a b ex pe ps io mr mw ir rd m2 rw h
   vec_t E_IF, E_IF_RST, E_ID, E_MADDR, E_MRD, E_MRD_RST, E_MWB, E_MWR;
   vec_t E_RWB, E_RWB_NOP, E_JMP, E_EXI_ADD, E_EXI_ORI, E_IWB, E_HALT;

   initial begin
      E_IF      = v(0, 0,0,1,0, 1,0, 0,1,0,1, 0,0,0,0);
      E_IF_RST  = v(0, 0,0,1,0, 0,0, 0,0,0,0, 0,0,0,0);
      E_ID      = v(1, 0,0,3,0, 0,0, 0,0,0,0, 0,0,0,0);
      E_MADDR   = v(2, 0,1,2,0, 0,0, 0,0,0,0, 0,0,0,0);
      E_MRD     = v(3, 0,0,0,0, 0,0, 1,1,0,0, 0,0,0,0);
      E_MRD_RST = v(3, 0,0,0,0, 0,0, 1,0,0,0, 0,0,0,0);
      E_MWB     = v(4, 0,0,0,0, 0,0, 0,0,0,0, 0,1,1,0);
      E_MWR     = v(5, 0,0,0,0, 0,0, 1,0,1,0, 0,0,0,0);
      E_RWB     = v(7, 0,0,0,0, 0,0, 0,0,0,0, 1,0,1,0);
      E_RWB_NOP = v(7, 0,0,0,0, 0,0, 0,0,0,0, 1,0,0,0);
      E_JMP     = v(9, 0,0,0,0, 1,2, 0,0,0,0, 0,0,0,0);
      E_EXI_ADD = v(10,0,1,2,0, 0,0, 0,0,0,0, 0,0,0,0);
      E_EXI_ORI = v(10,3,1,2,1, 0,0, 0,0,0,0, 0,0,0,0);
      E_IWB     = v(11,0,0,0,0, 0,0, 0,0,0,0, 0,0,1,0);
      E_HALT    = v(12,0,0,0,0, 0,0, 0,0,0,0, 0,0,0,1);
   end

   function automatic vec_t e_exr(input int op);
      return v(6, op,1,0,0, 0,0, 0,0,0,0, 0,0,0,0);
   endfunction

   function automatic vec_t e_br(input int z);
      return v(8, 1,1,0,0, z,1, 0,0,0,0, 0,0,0,0);
   endfunction

   task automatic step(input string nm, input vec_t e, input logic [31:0] c);
      exp_t x;
      @(posedge clk);
      #1;
      rst        = cur_rst;
      bus.opcode = cur_op;
      bus.funct  = cur_fn;
      bus.zero   = cur_z;
      x.nm  = nm;
      x.o   = e;
      x.cnt = c;
      q.push_back(x);
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t x;
         vec_t act;
         x = q.pop_front();
         act = v(int'(bus.state), int'(bus.alu_op), int'(bus.alu_src_a),
                 int'(bus.alu_src_b), int'(bus.ext_zero), int'(bus.pc_en),
                 int'(bus.pc_source), int'(bus.i_or_d), int'(bus.mem_read),
                 int'(bus.mem_write), int'(bus.ir_write), int'(bus.reg_dst),
                 int'(bus.mem_to_reg), int'(bus.reg_write), int'(bus.halted));
         n_total++;
         if (act === x.o) n_pass++;
         else $display("FAIL %s outs act=%06h exp=%06h", x.nm, act, x.o);
         n_total++;
         if (bus.instr_count === x.cnt) n_pass++;
         else $display("FAIL %s count act=%08h exp=%08h",
                       x.nm, bus.instr_count, x.cnt);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_pass  = 0;
      n_total = 0;
      cur_rst = 1'b1;
      cur_op  = 6'h00;
      cur_fn  = 6'h20;
      cur_z   = 1'b0;
      rst        = 1'b1;
      bus.opcode = 6'h00;
      bus.funct  = 6'h20;
      bus.zero   = 1'b0;

      step("reset", E_IF_RST, 0);
      cur_rst = 1'b0;

      // lw
      cur_op = 6'h23;
      step("lw_if", E_IF, 0);
      step("lw_id", E_ID, 0);
      step("lw_maddr", E_MADDR, 0);
      step("lw_mrd", E_MRD, 0);
      step("lw_mwb", E_MWB, 0);

      // R-type slt, sub, unknown funct
      cur_op = 6'h00; cur_fn = 6'h2A;
      step("slt_if", E_IF, 1);
      step("slt_id", E_ID, 1);
      step("slt_exr", e_exr(7), 1);
      step("slt_rwb", E_RWB, 1);
      cur_fn = 6'h22;
      step("sub_if", E_IF, 2);
      step("sub_id", E_ID, 2);
      step("sub_exr", e_exr(1), 2);
      step("sub_rwb", E_RWB, 2);
      cur_fn = 6'h03;
      step("nop_if", E_IF, 3);
      step("nop_id", E_ID, 3);
      step("nop_exr", e_exr(0), 3);
      step("nop_rwb", E_RWB_NOP, 3);

      // beq taken then not taken
      cur_op = 6'h04; cur_z = 1'b1;
      step("beq1_if", E_IF, 4);
      step("beq1_id", E_ID, 4);
      step("beq1_br", e_br(1), 4);
      cur_z = 1'b0;
      step("beq0_if", E_IF, 5);
      step("beq0_id", E_ID, 5);
      step("beq0_br", e_br(0), 5);

      // addi, sw, ori
      cur_op = 6'h08;
      step("addi_if", E_IF, 6);
      step("addi_id", E_ID, 6);
      step("addi_exi", E_EXI_ADD, 6);
      step("addi_iwb", E_IWB, 6);
      cur_op = 6'h2B;
      step("sw_if", E_IF, 7);
      step("sw_id", E_ID, 7);
      step("sw_maddr", E_MADDR, 7);
      step("sw_mwr", E_MWR, 7);
      cur_op = 6'h0D;
      step("ori_if", E_IF, 8);
      step("ori_id", E_ID, 8);
      step("ori_exi", E_EXI_ORI, 8);
      step("ori_iwb", E_IWB, 8);

      // illegal opcode then halt
      cur_op = 6'h3E;
      step("ill_if", E_IF, 9);
      step("ill_id", E_ID, 9);
      cur_op = 6'h3F;
      step("halt_if", E_IF, 9);
      step("halt_id", E_ID, 9);
      for (int i = 0; i < 20; i++) step("halt_hold", E_HALT, 9);

      // reset out of HALT
      cur_rst = 1'b1;
      step("halt_rst", E_HALT, 9);
      cur_rst = 1'b0;
      cur_op = 6'h23;
      step("post_rst_if", E_IF, 0);
      step("lwr_id", E_ID, 0);
      step("lwr_maddr", E_MADDR, 0);
      cur_rst = 1'b1;
      step("lwr_mrd_rst", E_MRD_RST, 0);
      cur_rst = 1'b0;

      // counter preload then j wraps it
      cur_op = 6'h02;
      step("j_if", E_IF, 32'hFFFF_FFFF);
      force dut.cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.cnt_q;
      step("j_id", E_ID, 32'hFFFF_FFFF);
      step("j_jmp", E_JMP, 32'hFFFF_FFFF);
      cur_op = 6'h23;
      step("wrap_if", E_IF, 0);

      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      @(posedge clk);
      if (q.size() != 0) begin
         n_total++;
         $display("FAIL drain act=%0d exp=0", q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
